// File: rtl/tcn_actmem_writeback.sv
// Write stage of the TCN activation memory: packs a pixel of ternary activations into
// base-3 bytes, buffers it, and writes it across the banks while avoiding in-flight reads.

module tcn_trit_encoder (
  input  logic [0:4][1:0] trits,
  output logic [7:0]      code
);
  // 01 -> digit 1, 11 -> digit 2, anything else -> 0; trit 0 is the least significant digit
  logic [4:0][7:0] digit;

  for (genvar gi = 0; gi < 5; gi++) begin : g_digit
    assign digit[gi] = (trits[gi] == 2'b01) ? 8'd1 :
                       (trits[gi] == 2'b11) ? 8'd2 : 8'd0;
  end

  assign code = digit[0] + 8'd3 * digit[1] + 8'd9 * digit[2]
              + 8'd27 * digit[3] + 8'd81 * digit[4];
endmodule

module tcn_actmem_writeback #(
  parameter  int N_I            = 512,
  parameter  int K              = 3,
  parameter  int WEIGHT_STAGGER = 8,
  parameter  int TCN_WIDTH      = 24,
  parameter  int FIFO_DEPTH     = 2,
  parameter  int MAX_STALL      = 4,
  localparam int NUMBANKS       = K * WEIGHT_STAGGER,
  localparam int EFF            = N_I / WEIGHT_STAGGER,
  localparam int PHYS           = ((EFF + 4) / 5) * 5,
  localparam int PBW            = PHYS / 5 * 8,
  localparam int NDEC           = PBW / 8,
  localparam int PW_W           = $clog2(WEIGHT_STAGGER) + 1,
  localparam int TS_W           = $clog2(TCN_WIDTH)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          valid_i,
  output logic                          ready_o,
  input  logic [0:N_I-1][1:0]           acts_i,
  input  logic [PW_W-1:0]               pixelwidth_i,
  input  logic [0:NUMBANKS-1]           read_enable_i,
  input  logic                          start_i,
  input  logic [TS_W-1:0]               tcn_len_i,
  input  logic [TS_W-1:0]               read_shift_i,
  output logic [0:NUMBANKS-1][PBW-1:0]  wdata_o,
  output logic [0:NUMBANKS-1]           write_enable_o,
  output logic                          set_shift_o,
  output logic [TS_W-1:0]               read_shift_o,
  output logic [TS_W-1:0]               write_shift_o,
  output logic [TS_W-1:0]               timestep_o,
  output logic                          seq_wrap_o,
  output logic                          forced_write_o
);
  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int STALL_W = $clog2(MAX_STALL + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, START, RUN} state_t;

  state_t state_reg, state_next;
  logic [WEIGHT_STAGGER-1:0][PBW-1:0] enc_words;
  logic [WEIGHT_STAGGER-1:0][PBW-1:0] word_mem [FIFO_DEPTH];
  logic [PW_W-1:0] n_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [STALL_W-1:0] stall_reg;
  logic [TS_W-1:0] timestep_reg, last_ts_reg, read_shift_reg, write_shift_reg;
  logic [PW_W-1:0] n_clamped, head_n;
  logic [TS_W-1:0] len_last;
  logic empty, full, reads_pending, issue, push, start_accept;

  // Word w takes trits [w*EFF +: EFF]; the last 5-trit group is zero-padded up to PHYS
  for (genvar gi = 0; gi < WEIGHT_STAGGER; gi++) begin : g_word
    for (genvar gj = 0; gj < NDEC; gj++) begin : g_grp
      logic [0:4][1:0] grp;
      for (genvar gk = 0; gk < 5; gk++) begin : g_trit
        if (gj * 5 + gk < EFF) begin : g_act
          assign grp[gk] = acts_i[gi * EFF + gj * 5 + gk];
        end else begin : g_pad
          assign grp[gk] = 2'b00;
        end
      end
      tcn_trit_encoder u_enc (
        .trits (grp),
        .code  (enc_words[gi][PBW-1-8*gj -: 8])
      );
    end
  end

  assign n_clamped = (pixelwidth_i == '0 || pixelwidth_i > PW_W'(WEIGHT_STAGGER))
                   ? PW_W'(WEIGHT_STAGGER) : pixelwidth_i;
  assign len_last  = (tcn_len_i == '0) ? TS_W'(TCN_WIDTH - 1) : tcn_len_i - 1'b1;

  assign empty         = (count_reg == '0);
  assign full          = (count_reg == CNT_W'(FIFO_DEPTH));
  assign reads_pending = |read_enable_i;
  assign head_n        = n_mem[rd_ptr_reg];
  // A write would win against the memory's pending reads, so hold off until the stall budget runs out
  assign issue          = !empty && (state_reg != START)
                       && (!reads_pending || stall_reg == STALL_W'(MAX_STALL));
  assign forced_write_o = issue && reads_pending;
  assign seq_wrap_o     = issue && (timestep_reg == last_ts_reg);
  assign push           = valid_i && ready_o;

  for (genvar gi = 0; gi < NUMBANKS; gi++) begin : g_bank
    if (gi < WEIGHT_STAGGER) begin : g_live
      assign write_enable_o[gi] = issue && (PW_W'(gi) < head_n);
      assign wdata_o[gi]        = write_enable_o[gi] ? word_mem[rd_ptr_reg][gi] : '0;
    end else begin : g_idle
      assign write_enable_o[gi] = 1'b0;
      assign wdata_o[gi]        = '0;
    end
  end

  always_comb begin
    state_next   = state_reg;
    start_accept = 1'b0;
    set_shift_o  = 1'b0;
    case (state_reg)
      START: begin
        state_next  = RUN;
        set_shift_o = 1'b1;
      end
      default: begin
        if (start_i && empty && !valid_i) begin
          state_next   = START;
          start_accept = 1'b1;
        end
      end
    endcase
    ready_o = (state_reg != START) && (!full || issue);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      word_mem[wr_ptr_reg] <= enc_words;
      n_mem[wr_ptr_reg]    <= n_clamped;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      stall_reg  <= '0;
    end else begin
      if (push)  wr_ptr_reg <= (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + 1'b1;
      if (issue) rd_ptr_reg <= (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + 1'b1;
      case ({push, issue})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      if (issue)                                        stall_reg <= '0;
      else if (!empty && stall_reg != STALL_W'(MAX_STALL)) stall_reg <= stall_reg + 1'b1;
    end
  end

  // Until the first start the sequence spans the full shift depth
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      timestep_reg    <= '0;
      last_ts_reg     <= TS_W'(TCN_WIDTH - 1);
      read_shift_reg  <= '0;
      write_shift_reg <= '0;
    end else if (start_accept) begin
      timestep_reg    <= '0;
      last_ts_reg     <= len_last;
      read_shift_reg  <= read_shift_i;
      write_shift_reg <= len_last;
    end else if (issue) begin
      timestep_reg <= seq_wrap_o ? '0 : timestep_reg + 1'b1;
    end
  end

  assign timestep_o    = timestep_reg;
  assign read_shift_o  = read_shift_reg;
  assign write_shift_o = write_shift_reg;
endmodule

// File: tb/tb_tcn_actmem_writeback.sv
// Scoreboard bench for tcn_actmem_writeback: stimulus queues expected writes, a negedge
// monitor pops and compares them whenever the DUT strobes a bank.

module tb_tcn_actmem_writeback;
  logic clk = 1'b0;
  logic rst_ni;
  logic valid_i, ready_o, start_i;
  logic [0:511][1:0] acts_i;
  logic [3:0] pixelwidth_i;
  logic [0:23] read_enable_i;
  logic [4:0] tcn_len_i, read_shift_i;
  logic [0:23][103:0] wdata_o;
  logic [0:23] write_enable_o;
  logic set_shift_o, seq_wrap_o, forced_write_o;
  logic [4:0] read_shift_o, write_shift_o, timestep_o;

  typedef struct {
    logic [0:23]       en;
    logic [7:0][103:0] words;
    logic              forced;
    logic              wrap;
    logic [4:0]        ts;
    int                cyc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int wrap_cnt = 0;
  int ts_model = 0;
  int len_model = 24;

  tcn_actmem_writeback dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .valid_i        (valid_i),
    .ready_o        (ready_o),
    .acts_i         (acts_i),
    .pixelwidth_i   (pixelwidth_i),
    .read_enable_i  (read_enable_i),
    .start_i        (start_i),
    .tcn_len_i      (tcn_len_i),
    .read_shift_i   (read_shift_i),
    .wdata_o        (wdata_o),
    .write_enable_o (write_enable_o),
    .set_shift_o    (set_shift_o),
    .read_shift_o   (read_shift_o),
    .write_shift_o  (write_shift_o),
    .timestep_o     (timestep_o),
    .seq_wrap_o     (seq_wrap_o),
    .forced_write_o (forced_write_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end else begin
      $display("ok   %s = 0x%0h (cycle %0d)", name, act, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [0:511][1:0] pattern(input int seed);
    logic [0:511][1:0] a;
    for (int i = 0; i < 512; i++) begin
      case ((i * 7 + seed * 5 + i / 3) % 3)
        0:       a[i] = 2'b00;
        1:       a[i] = 2'b01;
        default: a[i] = 2'b11;
      endcase
    end
    return a;
  endfunction

  function automatic logic [0:511][1:0] uniform(input logic [1:0] code);
    logic [0:511][1:0] a;
    for (int i = 0; i < 512; i++) a[i] = code;
    return a;
  endfunction

  // Base-3 packing: trit k of a group weighs 3^k, 01 -> 1, 11 -> 2, byte 0 at the top
  function automatic logic [7:0][103:0] model_words(input logic [0:511][1:0] a);
    logic [7:0][103:0] r;
    int v, p, j;
    r = '0;
    for (int w = 0; w < 8; w++) begin
      for (int g = 0; g < 13; g++) begin
        v = 0;
        p = 1;
        for (int k = 0; k < 5; k++) begin
          j = g * 5 + k;
          if (j < 64) begin
            if (a[w * 64 + j] == 2'b01)      v += p;
            else if (a[w * 64 + j] == 2'b11) v += 2 * p;
          end
          p *= 3;
        end
        r[w][103 - 8 * g -: 8] = v[7:0];
      end
    end
    return r;
  endfunction

  function automatic logic [7:0][103:0] repeat_word(input logic [103:0] word);
    logic [7:0][103:0] r;
    for (int w = 0; w < 8; w++) r[w] = word;
    return r;
  endfunction

  task automatic send(input logic [0:511][1:0] a, input logic [3:0] pw,
                      input logic [7:0][103:0] words, input bit track,
                      input int delay, input bit forced);
    exp_t x;
    int n;
    valid_i      = 1'b1;
    acts_i       = a;
    pixelwidth_i = pw;
    if (track) begin
      n = (pw == 4'd0 || pw > 4'd8) ? 8 : int'(pw);
      x.en = '0;
      for (int b = 0; b < n; b++) x.en[b] = 1'b1;
      x.words  = words;
      x.forced = forced;
      x.ts     = 5'(ts_model);
      x.wrap   = (ts_model == len_model - 1);
      ts_model = x.wrap ? 0 : ts_model + 1;
      x.cyc    = cyc + delay;
      sb_q.push_back(x);
    end
  endtask

  always @(negedge clk) begin : monitor
    int bad, idx;
    logic [103:0] expv;
    if (seq_wrap_o) wrap_cnt++;
    if (rst_ni && write_enable_o != '0) begin
      if (sb_q.size() == 0) begin
        check("unexpected_write", 128'(write_enable_o), 128'(0));
      end else begin
        mon_e = sb_q.pop_front();
        check("strobe", 128'(write_enable_o), 128'(mon_e.en));
        bad = -1;
        for (int b = 0; b < 24; b++) begin
          if (b < 8 && mon_e.en[b]) begin
            if (wdata_o[b] !== mon_e.words[b] && bad < 0) bad = b;
          end else if (b >= 8) begin
            if (wdata_o[b] !== '0 && bad < 0) bad = b;
          end
        end
        idx  = (bad < 0) ? 0 : bad;
        expv = '0;
        if (idx < 8 && mon_e.en[idx]) expv = mon_e.words[idx];
        check($sformatf("wdata_bank%0d", idx), 128'(wdata_o[idx]), 128'(expv));
        check("forced_write", 128'(forced_write_o), 128'(mon_e.forced));
        check("seq_wrap", 128'(seq_wrap_o), 128'(mon_e.wrap));
        check("timestep_at_write", 128'(timestep_o), 128'(mon_e.ts));
        check("write_cycle", 128'(cyc), 128'(mon_e.cyc));
      end
    end else if (rst_ni && (forced_write_o || seq_wrap_o)) begin
      check("stray_pulse", 128'({forced_write_o, seq_wrap_o}), 128'(0));
    end
  end

  initial begin : stimulus
    logic [7:0][103:0] hand_p, hand_m;
    logic [0:511][1:0] pat;
    int wrap_snap;
    hand_p = repeat_word({{12{8'h79}}, 8'h28});
    hand_m = repeat_word({{12{8'hF2}}, 8'h50});

    rst_ni = 1'b0; valid_i = 1'b0; start_i = 1'b0; acts_i = '0;
    pixelwidth_i = 4'd8; read_enable_i = '0; tcn_len_i = '0; read_shift_i = '0;
    repeat (3) tick();
    rst_ni = 1'b1;
    check("reset_ready", 128'(ready_o), 128'(1));
    check("reset_strobes", 128'(write_enable_o), 128'(0));
    check("reset_timestep", 128'(timestep_o), 128'(0));
    check("reset_write_shift", 128'(write_shift_o), 128'(0));
    check("reset_set_shift", 128'(set_shift_o), 128'(0));
    tick();

    // Full-width pixel, no reads: written the cycle after acceptance
    send(uniform(2'b01), 4'd8, hand_p, 1'b1, 1, 1'b0);
    tick(); valid_i = 1'b0;
    tick();
    check("ts_after_first", 128'(timestep_o), 128'(1));

    // Pixel width clamping
    send(uniform(2'b11), 4'd3, hand_m, 1'b1, 1, 1'b0);
    tick(); valid_i = 1'b0; tick();
    pat = pattern(1);
    send(pat, 4'd0, model_words(pat), 1'b1, 1, 1'b0);
    tick(); valid_i = 1'b0; tick();
    pat = pattern(2);
    send(pat, 4'd12, model_words(pat), 1'b1, 1, 1'b0);
    tick(); valid_i = 1'b0; tick();

    // Reads for 3 cycles delay the write, not forced
    pat = pattern(3);
    send(pat, 4'd8, model_words(pat), 1'b1, 4, 1'b0);
    tick(); valid_i = 1'b0; read_enable_i = 24'h000401;
    tick(); tick(); tick(); read_enable_i = '0;
    tick();

    // Reads held 10 cycles: forced write on the 5th
    pat = pattern(4);
    send(pat, 4'd8, model_words(pat), 1'b1, 5, 1'b1);
    tick(); valid_i = 1'b0; read_enable_i = 24'h800000;
    repeat (10) tick();
    read_enable_i = '0;
    tick();

    // FIFO fills under reads, third pixel refused, order kept on release
    read_enable_i = 24'h010000;
    pat = pattern(5);
    send(pat, 4'd6, model_words(pat), 1'b1, 3, 1'b0);
    tick();
    check("ready_one_entry", 128'(ready_o), 128'(1));
    pat = pattern(6);
    send(pat, 4'd8, model_words(pat), 1'b1, 3, 1'b0);
    tick();
    check("ready_full", 128'(ready_o), 128'(0));
    send(pattern(7), 4'd8, model_words(pattern(7)), 1'b0, 0, 1'b0);
    tick(); valid_i = 1'b0; read_enable_i = '0;
    tick(); tick();

    // New sequence of length 4
    start_i = 1'b1; tcn_len_i = 5'd4; read_shift_i = 5'd2;
    tick(); start_i = 1'b0;
    check("start_set_shift", 128'(set_shift_o), 128'(1));
    check("start_ready", 128'(ready_o), 128'(0));
    check("start_write_shift", 128'(write_shift_o), 128'(3));
    check("start_read_shift", 128'(read_shift_o), 128'(2));
    check("start_timestep", 128'(timestep_o), 128'(0));
    ts_model = 0; len_model = 4;
    tick();
    check("set_shift_one_cycle", 128'(set_shift_o), 128'(0));
    wrap_snap = wrap_cnt;
    for (int i = 0; i < 4; i++) begin
      pat = pattern(8 + i);
      send(pat, 4'd8, model_words(pat), 1'b1, 1, 1'b0);
      tick();
    end
    valid_i = 1'b0;
    tick();
    check("seq_timestep_wrapped", 128'(timestep_o), 128'(0));
    check("seq_wrap_count", 128'(wrap_cnt - wrap_snap), 128'(1));

    // Reset while the FIFO holds two entries
    pat = pattern(14);
    send(pat, 4'd8, model_words(pat), 1'b1, 1, 1'b0);
    tick(); valid_i = 1'b0; tick();
    read_enable_i = 24'h000010;
    send(pattern(12), 4'd8, model_words(pattern(12)), 1'b0, 0, 1'b0);
    tick();
    send(pattern(13), 4'd8, model_words(pattern(13)), 1'b0, 0, 1'b0);
    tick(); valid_i = 1'b0;
    check("full_before_reset", 128'(ready_o), 128'(0));
    check("ts_before_reset", 128'(timestep_o), 128'(1));
    rst_ni = 1'b0;
    tick(); tick();
    read_enable_i = '0; rst_ni = 1'b1;
    ts_model = 0; len_model = 24;
    check("post_reset_ready", 128'(ready_o), 128'(1));
    check("post_reset_timestep", 128'(timestep_o), 128'(0));
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post_reset_no_strobe", 128'(write_enable_o), 128'(0));
    end
    pat = pattern(15);
    send(pat, 4'd5, model_words(pat), 1'b1, 1, 1'b0);
    tick(); valid_i = 1'b0;
    tick(); tick();
    check("scoreboard_drained", 128'(sb_q.size()), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
